// File: rtl/iobuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iobuf_pkg
// Description : Shared encodings for the Bus Pirate IO buffer controller.
//               Holds the mode request encodings, the controller state
//               enumeration, and a helper that folds reserved modes onto HIZ.
// Revision    : 1.0 - initial release
// ============================================================================
package iobuf_pkg;

    localparam logic [1:0] IOBUF_MODE_HIZ  = 2'b00;
    localparam logic [1:0] IOBUF_MODE_PP   = 2'b01;
    localparam logic [1:0] IOBUF_MODE_OD   = 2'b10;
    localparam logic [1:0] IOBUF_MODE_RSVD = 2'b11;

    // Stable states: S_HIZ, S_PP, S_OD. Turnaround waits: S_DIR_ON, S_OE_OFF.
    typedef enum logic [2:0] {
        S_HIZ    = 3'd0,
        S_DIR_ON = 3'd1,
        S_PP     = 3'd2,
        S_OE_OFF = 3'd3,
        S_OD     = 3'd4
    } iobuf_state_t;

    // The reserved encoding behaves exactly like a HIZ request.
    function automatic logic [1:0] iobuf_norm_mode(input logic [1:0] i_mode);
        iobuf_norm_mode = (i_mode == IOBUF_MODE_RSVD) ? IOBUF_MODE_HIZ : i_mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iobuf_sync2.sv
`default_nettype none
// ============================================================================
// Module      : iobuf_sync2
// Description : Generic two-flop synchroniser with synchronous active-high
//               reset. Brings an asynchronous input into the clk domain with
//               two cycles of latency.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset (flops clear to 0)
//               i_d  - asynchronous input
//               o_q  - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module iobuf_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/iobuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iobuf_ctrl
// Description : Per-pin sequencer for one Bus Pirate IO buffer
//               (74LVC1T45 direction, 74LVC1G07 open-drain, FPGA tristate).
//               Accepts HIZ / push-pull / open-drain mode requests and
//               enforces break-before-make turnaround so the FPGA pin never
//               drives while the level shifter points toward the FPGA.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               mode_valid/mode       - mode request (00 HIZ,01 PP,10 OD,11=HIZ)
//               mode_ready, busy      - settled / transition in progress
//               cur_mode              - mode currently applied
//               dout                  - pin data (PP level, OD 0=low 1=release)
//               din_sync              - synchronised pin input
//               bufdir, bufod         - 74LVC1T45 DIR, 74LVC1G07 input
//               bufdat_tristate_*     - FPGA tristate pin oe/dout/din
// Revision    : 1.0 - initial release
// ============================================================================
module iobuf_ctrl
    import iobuf_pkg::*;
#(
    parameter int TURN_CYCLES = 4,
    parameter int CNT_W       = $clog2(TURN_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_valid,
    input  logic [1:0] mode,
    output logic       mode_ready,
    output logic [1:0] cur_mode,
    output logic       busy,
    input  logic       dout,
    output logic       din_sync,
    output logic       bufdir,
    output logic       bufod,
    output logic       bufdat_tristate_oe,
    output logic       bufdat_tristate_dout,
    input  logic       bufdat_tristate_din
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TURN_CYCLES - 1);

    iobuf_state_t r_state;
    iobuf_state_t w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]   r_target;
    logic [1:0]   w_target_nxt;
    logic [1:0]   w_req;
    logic         w_accept;
    logic         w_cnt_done;
    logic [1:0]   w_cur_mode_nxt;
    logic         w_ready_nxt;

    logic         r_mode_ready;
    logic         r_busy;
    logic [1:0]   r_cur_mode;
    logic         r_bufdir;
    logic         r_bufod;
    logic         r_oe;
    logic         r_tri_dout;

    assign w_req      = iobuf_norm_mode(mode);
    assign w_accept   = mode_valid && r_mode_ready;
    assign w_cnt_done = (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        case (r_state)
            S_HIZ: begin
                if (w_accept) begin
                    w_target_nxt = w_req;
                    if (w_req == IOBUF_MODE_PP)      w_state_nxt = S_DIR_ON;
                    else if (w_req == IOBUF_MODE_OD) w_state_nxt = S_OD;
                end
            end
            S_DIR_ON: begin
                if (w_cnt_done) w_state_nxt = S_PP;
            end
            S_PP: begin
                if (w_accept) begin
                    w_target_nxt = w_req;
                    if (w_req != IOBUF_MODE_PP) w_state_nxt = S_OE_OFF;
                end
            end
            S_OE_OFF: begin
                if (w_cnt_done) begin
                    w_state_nxt = (r_target == IOBUF_MODE_OD) ? S_OD : S_HIZ;
                end
            end
            S_OD: begin
                if (w_accept) begin
                    w_target_nxt = w_req;
                    if (w_req == IOBUF_MODE_PP)       w_state_nxt = S_DIR_ON;
                    else if (w_req == IOBUF_MODE_HIZ) w_state_nxt = S_HIZ;
                end
            end
            default: w_state_nxt = S_HIZ;
        endcase
    end

    // Counter restarts on every state change so each wait state spans
    // exactly TURN_CYCLES cycles.
    always_comb begin
        w_cnt_nxt = '0;
        if ((w_state_nxt == r_state) &&
            ((r_state == S_DIR_ON) || (r_state == S_OE_OFF))) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Status derived from the state being entered so all outputs are
    // registered and line up with the state register.
    always_comb begin
        w_cur_mode_nxt = r_cur_mode;
        w_ready_nxt    = 1'b0;
        case (w_state_nxt)
            S_HIZ: begin w_cur_mode_nxt = IOBUF_MODE_HIZ; w_ready_nxt = 1'b1; end
            S_PP:  begin w_cur_mode_nxt = IOBUF_MODE_PP;  w_ready_nxt = 1'b1; end
            S_OD:  begin w_cur_mode_nxt = IOBUF_MODE_OD;  w_ready_nxt = 1'b1; end
            default: begin
                w_cur_mode_nxt = r_cur_mode;
                w_ready_nxt    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_HIZ;
            r_cnt        <= '0;
            r_target     <= IOBUF_MODE_HIZ;
            r_mode_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_cur_mode   <= IOBUF_MODE_HIZ;
            r_bufdir     <= 1'b0;
            r_bufod      <= 1'b1;
            r_oe         <= 1'b0;
            r_tri_dout   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_target     <= w_target_nxt;
            r_mode_ready <= w_ready_nxt;
            r_busy       <= !w_ready_nxt;
            r_cur_mode   <= w_cur_mode_nxt;
            // Direction is toward the header in every state that may drive.
            r_bufdir     <= (w_state_nxt == S_DIR_ON) || (w_state_nxt == S_PP) ||
                            (w_state_nxt == S_OE_OFF);
            r_oe         <= (w_state_nxt == S_PP);
            r_bufod      <= (w_state_nxt == S_OD) ? dout : 1'b1;
            r_tri_dout   <= dout;
        end
    end

    iobuf_sync2 #(
        .WIDTH (1)
    ) u_din_sync (
        .clk (clock),
        .rst (reset),
        .i_d (bufdat_tristate_din),
        .o_q (din_sync)
    );

    assign mode_ready           = r_mode_ready;
    assign busy                 = r_busy;
    assign cur_mode             = r_cur_mode;
    assign bufdir               = r_bufdir;
    assign bufod                = r_bufod;
    assign bufdat_tristate_oe   = r_oe;
    assign bufdat_tristate_dout = r_tri_dout;

endmodule
`default_nettype wire

// File: tb/tb_iobuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iobuf_ctrl
// Description : Directed self-checking bench for iobuf_ctrl (TURN_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iobuf_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       mode_ready;
    logic [1:0] cur_mode;
    logic       busy;
    logic       dout = 1'b0;
    logic       din_sync;
    logic       bufdir;
    logic       bufod;
    logic       bufdat_tristate_oe;
    logic       bufdat_tristate_dout;
    logic       bufdat_tristate_din = 1'b0;

    int errors = 0;
    int checks = 0;
    int contention = 0;

    iobuf_ctrl #(.TURN_CYCLES(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .mode_valid           (mode_valid),
        .mode                 (mode),
        .mode_ready           (mode_ready),
        .cur_mode             (cur_mode),
        .busy                 (busy),
        .dout                 (dout),
        .din_sync             (din_sync),
        .bufdir               (bufdir),
        .bufod                (bufod),
        .bufdat_tristate_oe   (bufdat_tristate_oe),
        .bufdat_tristate_dout (bufdat_tristate_dout),
        .bufdat_tristate_din  (bufdat_tristate_din)
    );

    always #5 clock = ~clock;

    // Contention watch: FPGA driving while the shifter points at the FPGA.
    always @(negedge clock) begin
        if (!reset && bufdir === 1'b0 && bufdat_tristate_oe === 1'b1) contention++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Compact status snapshot: {bufdir, bufod, oe, mode_ready, busy, cur_mode}
    function automatic logic [6:0] snap();
        snap = {bufdir, bufod, bufdat_tristate_oe, mode_ready, busy, cur_mode};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL reset_status: got %b expected 0101000", snap());
        end
        checks++;
        if (din_sync !== 1'b0 || bufdat_tristate_dout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got din_sync=%b dout=%b expected 0 0", din_sync, bufdat_tristate_dout);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_same_mode();
        mode = 2'b00; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL same_mode_hiz: got %b expected 0101000", snap());
        end
    endtask

    task automatic test_hiz_to_pp();
        dout = 1'b0;
        mode = 2'b01; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (snap() !== 7'b1_1_0_0_1_00) begin
                errors++;
                $display("FAIL hiz_pp_wait%0d: got %b expected 1100100", i, snap());
            end
            if (i < 4) step();
        end
        step();
        checks++;
        if (snap() !== 7'b1_1_1_1_0_01) begin
            errors++;
            $display("FAIL hiz_pp_settled: got %b expected 1111001", snap());
        end
        dout = 1'b1;
        checks++;
        if (bufdat_tristate_dout !== 1'b0) begin
            errors++;
            $display("FAIL pp_dout_early: got %b expected 0", bufdat_tristate_dout);
        end
        step();
        checks++;
        if (bufdat_tristate_dout !== 1'b1) begin
            errors++;
            $display("FAIL pp_dout_late: got %b expected 1", bufdat_tristate_dout);
        end
    endtask

    task automatic test_pp_to_hiz();
        mode = 2'b00; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (snap() !== 7'b1_1_0_0_1_01) begin
                errors++;
                $display("FAIL pp_hiz_wait%0d: got %b expected 1100101", i, snap());
            end
            if (i < 4) step();
        end
        step();
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL pp_hiz_settled: got %b expected 0101000", snap());
        end
    endtask

    task automatic test_hiz_to_od();
        logic [2:0] pat;
        pat = 3'b010;
        dout = 1'b0;
        mode = 2'b10; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        checks++;
        if (snap() !== 7'b0_0_0_1_0_10) begin
            errors++;
            $display("FAIL hiz_od_entry: got %b expected 0001010", snap());
        end
        for (int i = 2; i >= 0; i--) begin
            dout = pat[i];
            step();
            checks++;
            if (bufod !== pat[i] || bufdir !== 1'b0 || bufdat_tristate_oe !== 1'b0) begin
                errors++;
                $display("FAIL od_follow%0d: got od=%b dir=%b oe=%b expected od=%b dir=0 oe=0",
                         i, bufod, bufdir, bufdat_tristate_oe, pat[i]);
            end
        end
        dout = 1'b1;
        checks++;
        if (bufod !== 1'b0) begin
            errors++;
            $display("FAIL od_latency: got %b expected 0", bufod);
        end
    endtask

    task automatic test_od_to_pp();
        // Currently S_OD with bufod=0; release must happen with dir going high.
        dout = 1'b0;
        step();
        mode = 2'b01; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        checks++;
        if (snap() !== 7'b1_1_0_0_1_10) begin
            errors++;
            $display("FAIL od_pp_entry: got %b expected 1100110", snap());
        end
        repeat (4) step();
        checks++;
        if (snap() !== 7'b1_1_1_1_0_01) begin
            errors++;
            $display("FAIL od_pp_settled: got %b expected 1111001", snap());
        end
        mode = 2'b00; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL od_pp_return: got %b expected 0101000", snap());
        end
    endtask

    task automatic test_busy_request();
        dout = 1'b1;
        mode = 2'b01; mode_valid = 1'b1;
        step();
        mode = 2'b10;  // held valid while busy; must wait for S_PP
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (mode_ready !== 1'b0 || cur_mode !== 2'b00) begin
                errors++;
                $display("FAIL busy_ignore%0d: got ready=%b cur=%b expected ready=0 cur=00",
                         i, mode_ready, cur_mode);
            end
            if (i < 4) step();
        end
        step();
        checks++;
        if (snap() !== 7'b1_1_1_1_0_01) begin
            errors++;
            $display("FAIL busy_reach_pp: got %b expected 1111001", snap());
        end
        step();
        mode_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (snap() !== 7'b1_1_0_0_1_01) begin
                errors++;
                $display("FAIL pp_od_wait%0d: got %b expected 1100101", i, snap());
            end
            if (i < 4) step();
        end
        step();
        checks++;
        if (snap() !== 7'b0_1_0_1_0_10) begin
            errors++;
            $display("FAIL pp_od_settled: got %b expected 0101010", snap());
        end
        mode = 2'b11; mode_valid = 1'b1;  // reserved behaves as HIZ
        step();
        mode_valid = 1'b0;
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL rsvd_to_hiz: got %b expected 0101000", snap());
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b01; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 0101000", snap());
        end
        reset = 1'b0;
        step();
        mode = 2'b01; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (snap() !== 7'b1_1_1_1_0_01) begin
            errors++;
            $display("FAIL reset_mid_full_wait: got %b expected 1111001", snap());
        end
    endtask

    task automatic test_din_sync();
        bufdat_tristate_din = 1'b1;
        step();
        checks++;
        if (din_sync !== 1'b0) begin
            errors++;
            $display("FAIL din_sync_lat1: got %b expected 0", din_sync);
        end
        step();
        checks++;
        if (din_sync !== 1'b1) begin
            errors++;
            $display("FAIL din_sync_lat2: got %b expected 1", din_sync);
        end
        bufdat_tristate_din = 1'b0;
        repeat (2) step();
        checks++;
        if (din_sync !== 1'b0) begin
            errors++;
            $display("FAIL din_sync_fall: got %b expected 0", din_sync);
        end
    endtask

    task automatic test_storm();
        int bad_busy;
        int waited;
        bad_busy = 0;
        for (int i = 0; i < 10000; i++) begin
            mode_valid = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            dout = 1'($urandom_range(0, 1));
            bufdat_tristate_din = 1'($urandom_range(0, 1));
            step();
            if (busy !== !mode_ready) bad_busy++;
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL storm_busy: got %0d bad cycles expected 0", bad_busy);
        end
        mode_valid = 1'b0;
        waited = 0;
        while (mode_ready !== 1'b1 && waited < 20) begin step(); waited++; end
        mode = 2'b00; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        waited = 0;
        while (mode_ready !== 1'b1 && waited < 20) begin step(); waited++; end
        checks++;
        if (snap() !== 7'b0_1_0_1_0_00) begin
            errors++;
            $display("FAIL storm_drain: got %b expected 0101000", snap());
        end
        checks++;
        if (contention != 0) begin
            errors++;
            $display("FAIL contention: got %0d cycles expected 0", contention);
        end
    endtask

    initial begin
        test_reset();
        test_same_mode();
        test_hiz_to_pp();
        test_pp_to_hiz();
        test_hiz_to_od();
        test_od_to_pp();
        test_busy_request();
        test_reset_mid();
        test_din_sync();
        test_storm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iobuf_ctrl.md
Name: iobuf_ctrl

Overview:
- Per-pin controller sequencing one Bus Pirate IO buffer: 74LVC1T45 direction, 74LVC1G07 open-drain and FPGA tristate pin.
- Accepts mode requests (HiZ/input, push-pull out, open-drain out).
- Enforces break-before-make turnaround so the FPGA pin never drives while the 74LVC1T45 is in input direction.
- Sits between the protocol engines/register file and the buffer pins, one instance per IO.

Parameters:
- TURN_CYCLES, 4, clock cycles of turnaround between direction change and FPGA output enable change; legal range >=1.
- CNT_W, $clog2(TURN_CYCLES+1), turnaround counter width (derived; do not override).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mode_valid  input  1  mode request valid
- mode  input  2  requested mode: 00 HIZ, 01 PP, 10 OD, 11 reserved (treated as HIZ)
- mode_ready  output  1  controller settled; request accepted on mode_valid&&mode_ready
- cur_mode  output  2  settled mode currently applied (held during transitions)
- busy  output  1  transition in progress (equals !mode_ready)
- dout  input  1  pin data; PP drives level, OD: 0 pulls low / 1 releases
- din_sync  output  1  2-FF synchronised pin input, valid in all modes
- bufdir  output  1  74LVC1T45 DIR, 1 = FPGA to header
- bufod  output  1  74LVC1G07 input, 1 = HiZ, 0 = GND
- bufdat_tristate_oe  output  1  FPGA pin output enable
- bufdat_tristate_dout  output  1  FPGA pin output data
- bufdat_tristate_din  input  1  FPGA pin input data (asynchronous)

Behaviour:
- All outputs registered. Reset values:
  - bufdir=0, bufod=1, bufdat_tristate_oe=0, bufdat_tristate_dout=0
  - mode_ready=1, busy=0, cur_mode=00, din_sync=0
  - state=S_HIZ, counter=0
- States and pin settings:
  - S_HIZ (dir0 od1 oe0)
  - S_DIR_ON (dir1 od1 oe0)
  - S_PP (dir1 od1 oe1)
  - S_OE_OFF (dir1 od1 oe0)
  - S_OD (dir0 od=dout_q oe0)
- mode_ready=1 only in S_HIZ, S_PP, S_OD.
- Transitions, on accept:
  - HIZ->PP: S_DIR_ON, hold TURN_CYCLES cycles, then S_PP.
  - HIZ->OD: S_OD next cycle.
  - OD->HIZ: S_HIZ next cycle.
  - OD->PP: bufod=1 and S_DIR_ON in the same cycle, then as above.
  - PP->HIZ/OD: S_OE_OFF, hold TURN_CYCLES cycles, then dir=0 and land in target (S_HIZ or S_OD).
- Target mode is latched at accept. mode/mode_valid are ignored while busy; the requester holds the request.
- Same-mode request: accepted, no state change, mode_ready stays 1.
- Counter loads 0 on entry to a wait state and exits when counter==TURN_CYCLES-1. Each wait state lasts exactly TURN_CYCLES cycles.
- Invariant, every cycle: never (bufdir==0 && bufdat_tristate_oe==1).
- dout path:
  - bufdat_tristate_dout = dout registered every cycle (1-cycle latency), in all states.
  - bufod in S_OD = dout registered (1-cycle latency); bufod=1 in all other states.
- cur_mode updates in the cycle the target state is entered.
- din_sync: two flops from bufdat_tristate_din; 2-cycle latency; reset to 0.
- Reset mid-transition (any state): next cycle S_HIZ values. oe and dir drop together, which is legal since oe=0.

Decomposition:
- Package iobuf_pkg holds:
  - mode encodings IOBUF_MODE_HIZ/PP/OD/RSVD
  - state enum typedef iobuf_state_t
- Sub-module iobuf_sync2: generic 2-flop synchroniser with synchronous reset. Used for din_sync and reusable by sibling blocks.

Test Plan:
- Reset check: assert reset 3 cycles -> bufdir=0, bufod=1, oe=0, mode_ready=1, cur_mode=00, din_sync=0.
- HIZ->PP, TURN_CYCLES=4, accept at edge N:
  - bufdir=1 from N+1.
  - oe=1, cur_mode=01, mode_ready=1 at N+5.
  - dout toggle 0->1 appears on bufdat_tristate_dout 1 cycle later.
- PP->HIZ, accept at N:
  - oe=0 at N+1.
  - bufdir stays 1 through N+4, bufdir=0 and cur_mode=00 at N+5.
  - Contention monitor never fires.
- HIZ->OD, dout pattern 0,1,0 -> bufod follows 0,1,0 delayed 1 cycle; bufdir=0 and oe=0 throughout.
- Request during S_DIR_ON (mode=10 held valid) -> mode_ready=0 until S_PP, then accepted; S_OE_OFF 4 cycles, final state S_OD.
- Reset asserted in 2nd cycle of S_DIR_ON -> next cycle bufdir=0, oe=0, S_HIZ. Random request storm of 10k cycles: invariant holds every cycle.
